// File: rtl/timing_gen_if.sv
// timing_gen_if: start request, controller feedback and beat/machine-cycle outputs of the timing generator
interface timing_gen_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             short_i;
    logic             long_i;
    logic             stop_i;
    logic             t1_o;
    logic             t2_o;
    logic             t3_o;
    logic             w1_o;
    logic             w2_o;
    logic             w3_o;
    logic             running_o;
    logic [CNT_W-1:0] cyc_cnt_o;
    modport master (
        input  start_i, short_i, long_i, stop_i,
        output t1_o, t2_o, t3_o, w1_o, w2_o, w3_o, running_o, cyc_cnt_o
    );
    modport slave (
        output start_i, short_i, long_i, stop_i,
        input  t1_o, t2_o, t3_o, w1_o, w2_o, w3_o, running_o, cyc_cnt_o
    );
endinterface

// File: rtl/timing_gen.sv
// timing_gen: beat (t1..t3) and machine-cycle (w1..w3) sequencer for the hardwired controller
module timing_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input logic          clk,
    input logic          clr,
    timing_gen_if.master bus
);
    // one-hot beat encoding so the state register drives t1..t3 directly
    typedef enum logic [2:0] {HALT = 3'b000, T1 = 3'b001, T2 = 3'b010, T3 = 3'b100} beat_e;
    beat_e                  state_q, state_d;
    logic [2:0]             w_q, w_d, w_adv;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last_q;
    logic                   rise, eoc;
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state_q     <= HALT;
            w_q         <= 3'b001;
            cnt_q       <= '0;
            sync_q      <= '0;
            sync_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.start_i};
            sync_last_q <= sync_q[SYNC_STAGES-1];
        end
    // short/long/stop only matter on the t3 edge that closes a machine cycle
    always_comb begin
        rise    = sync_q[SYNC_STAGES-1] & ~sync_last_q;
        eoc     = state_q == T3;
        w_adv   = w_q[0] ? (bus.short_i ? 3'b001 : 3'b010) :
                  w_q[1] ? (bus.long_i  ? 3'b100 : 3'b001) : 3'b001;
        state_d = state_q == HALT ? (rise ? T1 : HALT) :
                  state_q == T1   ? T2 :
                  state_q == T2   ? T3 : (bus.stop_i ? HALT : T1);
        w_d     = eoc ? w_adv : w_q;
        cnt_d   = cnt_q + CNT_W'(eoc);
    end
    assign bus.t1_o      = state_q[0];
    assign bus.t2_o      = state_q[1];
    assign bus.t3_o      = state_q[2];
    assign bus.w1_o      = w_q[0];
    assign bus.w2_o      = w_q[1];
    assign bus.w3_o      = w_q[2];
    assign bus.running_o = |state_q;
    assign bus.cyc_cnt_o = cnt_q;
endmodule

// File: tb/tb_timing_gen.sv
// tb_timing_gen: vector table plus hand sequences, expected results queued at drive time
module tb_timing_gen;
    localparam int SYNC = 2;
    localparam int CW   = 4;
    typedef struct packed {
        logic st, sh, lg, sp;
        logic [2:0] t, w;
        logic [3:0] c;
    } vec_t;
    typedef struct packed {
        logic [2:0] t, w;
        logic       r;
        logic [3:0] c;
    } exp_t;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    vec_t tbl[35];
    timing_gen_if #(.CNT_W(CW)) bus ();
    timing_gen #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;
    function automatic exp_t dut_out();
        return '{t: {bus.t3_o, bus.t2_o, bus.t1_o}, w: {bus.w3_o, bus.w2_o, bus.w1_o},
                 r: bus.running_o, c: bus.cyc_cnt_o};
    endfunction
    task automatic check(input string nm, input exp_t g, input exp_t e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got t=%b w=%b run=%b cnt=%0d, want t=%b w=%b run=%b cnt=%0d",
                     nm, g.t, g.w, g.r, g.c, e.t, e.w, e.r, e.c);
        end
    endtask
    task automatic step(input string nm, input logic st, sh, lg, sp,
                        input logic [2:0] et, ew, input logic [3:0] ec);
        exp_t e;
        @(negedge clk);
        bus.start_i = st;
        bus.short_i = sh;
        bus.long_i  = lg;
        bus.stop_i  = sp;
        exp_q.push_back('{t: et, w: ew, r: |et, c: ec});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(nm, dut_out(), e);
    endtask
    task automatic pulse_reset(input string nm);
        @(negedge clk);
        #2 clr = 1'b0;
        #1 check(nm, dut_out(), '{t: 3'b000, w: 3'b001, r: 1'b0, c: 4'd0});
        @(negedge clk);
        clr = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
    initial begin
        int b, c;
        logic [2:0] ew;
        tbl = '{
            '{1,0,0,0,3'b000,3'b001,4'd0}, '{1,0,0,0,3'b000,3'b001,4'd0},
            '{0,0,0,0,3'b001,3'b001,4'd0}, '{0,0,0,0,3'b010,3'b001,4'd0},
            '{0,0,0,0,3'b100,3'b001,4'd0}, '{0,0,0,0,3'b001,3'b010,4'd1},
            '{0,0,1,0,3'b010,3'b010,4'd1}, '{0,0,0,0,3'b100,3'b010,4'd1},
            '{0,0,1,0,3'b001,3'b100,4'd2}, '{0,0,0,0,3'b010,3'b100,4'd2},
            '{0,0,0,0,3'b100,3'b100,4'd2}, '{0,1,1,0,3'b001,3'b001,4'd3},
            '{0,0,0,0,3'b010,3'b001,4'd3}, '{0,0,0,0,3'b100,3'b001,4'd3},
            '{0,0,1,0,3'b001,3'b010,4'd4}, '{0,0,0,0,3'b010,3'b010,4'd4},
            '{0,0,0,0,3'b100,3'b010,4'd4}, '{0,0,0,0,3'b001,3'b001,4'd5},
            '{0,0,0,0,3'b010,3'b001,4'd5}, '{0,0,0,0,3'b100,3'b001,4'd5},
            '{0,1,0,0,3'b001,3'b001,4'd6}, '{0,0,0,1,3'b010,3'b001,4'd6},
            '{0,1,0,0,3'b100,3'b001,4'd6}, '{0,1,0,1,3'b000,3'b001,4'd7},
            '{0,1,1,1,3'b000,3'b001,4'd7}, '{1,0,0,0,3'b000,3'b001,4'd7},
            '{1,0,0,0,3'b000,3'b001,4'd7}, '{1,0,0,0,3'b001,3'b001,4'd7},
            '{1,0,0,0,3'b010,3'b001,4'd7}, '{1,0,0,0,3'b100,3'b001,4'd7},
            '{1,0,0,1,3'b000,3'b010,4'd8}, '{1,0,0,0,3'b000,3'b010,4'd8},
            '{0,0,0,0,3'b000,3'b010,4'd8}, '{0,0,0,0,3'b000,3'b010,4'd8},
            '{0,0,0,0,3'b000,3'b010,4'd8}
        };
        bus.start_i = 1'b0;
        bus.short_i = 1'b0;
        bus.long_i  = 1'b0;
        bus.stop_i  = 1'b0;
        #1 clr = 1'b0;
        #1 check("reset", dut_out(), '{t: 3'b000, w: 3'b001, r: 1'b0, c: 4'd0});
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", dut_out(), '{t: 3'b000, w: 3'b001, r: 1'b0, c: 4'd0});
        clr = 1'b1;
        for (int i = 0; i < 35; i++)
            step($sformatf("vec%0d", i), tbl[i].st, tbl[i].sh, tbl[i].lg, tbl[i].sp,
                 tbl[i].t, tbl[i].w, tbl[i].c);
        // restart from w2 with start held 20 clocks; stop mid-way must not retrigger
        for (int i = 0; i < 22; i++) begin
            b  = (i - 2) % 3;
            c  = (i - 2) / 3;
            ew = (c % 2 == 0) ? 3'b010 : 3'b001;
            if (i < 2)
                step($sformatf("held%0d", i), 1'b1, 0, 0, 0, 3'b000, 3'b010, 4'd8);
            else if (i < 8)
                step($sformatf("held%0d", i), 1'b1, 0, 0, 0, 3'(1 << b), ew, 4'(8 + c));
            else
                step($sformatf("held%0d", i), i < 20, 0, 0, i == 8, 3'b000, 3'b010, 4'd10);
        end
        // start rise on the same edge as a stop end-of-cycle is ignored
        step("coll0", 1, 0, 0, 0, 3'b000, 3'b010, 4'd10);
        step("coll1", 0, 0, 0, 0, 3'b000, 3'b010, 4'd10);
        step("coll2", 0, 0, 0, 0, 3'b001, 3'b010, 4'd10);
        step("coll3", 1, 0, 0, 0, 3'b010, 3'b010, 4'd10);
        step("coll4", 0, 0, 0, 0, 3'b100, 3'b010, 4'd10);
        step("coll5", 0, 0, 1, 1, 3'b000, 3'b100, 4'd11);
        step("coll6", 0, 0, 0, 0, 3'b000, 3'b100, 4'd11);
        step("coll7", 0, 0, 0, 0, 3'b000, 3'b100, 4'd11);
        step("coll8", 0, 0, 0, 0, 3'b000, 3'b100, 4'd11);
        // counter wrap over 17 cycles, then async reset during w2 t2
        pulse_reset("reset_mid");
        for (int i = 0; i < 55; i++) begin
            b  = (i - 2) % 3;
            c  = (i - 2) / 3;
            ew = (c % 2 == 0) ? 3'b001 : 3'b010;
            if (i < 2)
                step($sformatf("wrap%0d", i), i == 0, 0, 0, 0, 3'b000, 3'b001, 4'd0);
            else
                step($sformatf("wrap%0d", i), 1'b0, 0, 0, 0, 3'(1 << b), ew, 4'(c % 16));
        end
        pulse_reset("reset_w2t2");
        step("post_reset", 0, 1, 1, 1, 3'b000, 3'b001, 4'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
